spike_address_dispatcher: RTL and testbench
===========================================

Name: spike_address_dispatcher

Overview:
Transmit end of the spike-address bus consumed by the MAC units. Captures one timestep's spike vector from a layer of NUM_NEURONS neurons and serialises each set bit as a 12-bit source address with a valid/ready handshake. After the last address it closes the timestep by driving the clear strobe the MACs use to latch incoming spikes and emit weighted sums.

Parameters:
NUM_NEURONS, 10, neurons in the sending layer (bits of spike_in)
ADDR_W, 12, source address width
BASE_ADDR, 0, address of neuron 0; neuron i transmits BASE_ADDR+i
CLEAR_CYCLES, 4, cycles clear is held high at timestep end (min 1)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  asynchronous, active-high reset
spike_in  in  NUM_NEURONS  spike flags for the finished timestep, bit i = neuron i
spike_valid  in  1  spike_in valid this cycle; accepted only when capture_ready=1
capture_ready  out  1  dispatcher idle, can accept a spike vector
source_address  out  ADDR_W  address of the neuron currently being sent
addr_valid  out  1  source_address valid
addr_ready  in  1  receivers accept source_address this cycle
clear  out  1  timestep boundary strobe to MACs
done  out  1  one-cycle pulse when clear deasserts (timestep fully closed)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state, mid-transfer included): state=IDLE, pending=0, source_address=0, addr_valid=0, clear=0, done=0, busy=0, capture_ready=1. A vector in flight is discarded.
- States: IDLE, SEND, CLEAR.
- IDLE: capture_ready=1. When spike_valid=1, latch pending<=spike_in. If spike_in!=0, go to SEND. If spike_in==0, skip to CLEAR, because an empty timestep still issues clear.
- SEND: addr_valid=1 and source_address=BASE_ADDR+lowest set index of pending. Both are registered and stable until the handshake.
  - On addr_valid&&addr_ready, clear that bit. In the same cycle, present the next lowest index, so the bus sustains one address per cycle with no bubble.
  - When the final bit is accepted, go to CLEAR. addr_valid drops the next cycle.
  - Addresses are sent strictly in ascending neuron index.
- CLEAR: addr_valid=0 and clear=1 for exactly CLEAR_CYCLES cycles, counted by a down-counter. The cycle after clear falls, done=1 for 1 cycle and the state returns to IDLE.
- Latency from accepted spike_valid to the first addr_valid is 1 cycle. With addr_ready tied high, a vector of k spikes produces clear at cycle k+1 after capture.
- spike_valid while capture_ready=0 is ignored; it has no effect and is not queued. The producer must hold spike_valid until capture_ready.
- addr_ready while addr_valid=0 is ignored.
- Address arithmetic: BASE_ADDR+i is truncated to ADDR_W, wrapping modulo 2^ADDR_W. Elaboration fails if NUM_NEURONS > 2^ADDR_W.
- No address is ever emitted while clear=1. clear and addr_valid are never high in the same cycle.

Optional Feature:
SPIKE_COUNT_EN
- Defined: adds output spike_count [$clog2(NUM_NEURONS+1)-1:0].
  - Zeroed on reset and on vector capture.
  - Increments on each accepted address.
  - Holds its final value from the start of CLEAR until the next capture, for activity monitoring.
- Undefined: no port and no counter logic.

Decomposition:
- Package snn_spike_pkg holds:
  - ADDR_W default constant
  - state enum (IDLE, SEND, CLEAR)
  - a function computing the lowest-set-index width
- One sub-module, lowest_set_index: parameterised combinational priority encoder over NUM_NEURONS bits. It returns the index and an any_set flag and drives the next-address mux.

Test Plan:
- Reset mid-SEND (spike_in=10'b0000000111, RST pulsed after first handshake) -> addr_valid=0, clear=0, capture_ready=1 asynchronously; no further addresses.
- spike_in=10'b0000000101, addr_ready=1 -> addresses 0 then 2 on consecutive cycles, then clear high 4 cycles, then done 1 cycle.
- Same vector, addr_ready low for 3 cycles on first address -> address 0 and addr_valid held stable 3 cycles, then 0, 2 delivered, none duplicated or lost.
- spike_in=0 with spike_valid -> no addr_valid; clear high 4 cycles, done pulse.
- All 10 bits set, BASE_ADDR=4090 -> addresses 4090..4095, 0..3 in order, then clear; spike_count=10 with SPIKE_COUNT_EN.
- spike_valid asserted with spike_in=10'b1 during SEND -> ignored; only the original vector's addresses appear.

Source files
------------

// File: rtl/snn_spike_pkg.sv
//------------------------------------------------------------------------------
// Module  : snn_spike_pkg
// Brief   : Shared constants, FSM state type and width helper for the
//           spike-address dispatcher.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package snn_spike_pkg;

    localparam int ADDR_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Bits needed to index n items, never less than one.
    function automatic int lsi_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lowest_set_index.sv
//------------------------------------------------------------------------------
// Module  : lowest_set_index
// Brief   : Combinational priority encoder returning the lowest set bit index.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lowest_set_index
    import snn_spike_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int IDX_W = lsi_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any_set
);

    // Scan high to low so the last hit written is the lowest index.
    always_comb begin
        o_idx     = '0;
        o_any_set = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx     = IDX_W'(i);
                o_any_set = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spike_address_dispatcher.sv
//------------------------------------------------------------------------------
// Module  : spike_address_dispatcher
// Brief   : Serialises a timestep spike vector into source addresses, then
//           closes the timestep with a clear strobe. Optional SPIKE_COUNT_EN
//           adds a per-timestep accepted-address counter output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spike_address_dispatcher
    import snn_spike_pkg::*;
#(
    parameter int NUM_NEURONS  = 10,
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int BASE_ADDR    = 0,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   spike_valid,
    output logic                   capture_ready,
    output logic [ADDR_W-1:0]      source_address,
    output logic                   addr_valid,
    input  logic                   addr_ready,
    output logic                   clear,
    output logic                   done,
    output logic                   busy
`ifdef SPIKE_COUNT_EN
    ,
    output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count
`endif
);

    localparam int c_idx_w = lsi_width(NUM_NEURONS);
    localparam int c_clr_w = lsi_width(CLEAR_CYCLES);
    localparam logic [ADDR_W-1:0]      c_base     = ADDR_W'(BASE_ADDR);
    localparam logic [NUM_NEURONS-1:0] c_one      = NUM_NEURONS'(1);
    localparam logic [c_clr_w-1:0]     c_clr_load = c_clr_w'(CLEAR_CYCLES - 1);

    if (NUM_NEURONS > (64'd1 << ADDR_W)) begin : g_addr_range_check
        $error("NUM_NEURONS exceeds the ADDR_W address space");
    end

    state_t                   r_state,    w_state_nxt;
    logic [NUM_NEURONS-1:0]   r_pending,  w_pending_nxt;
    logic [c_idx_w-1:0]       r_cur_idx,  w_cur_idx_nxt;
    logic [ADDR_W-1:0]        r_addr,     w_addr_nxt;
    logic                     r_valid,    w_valid_nxt;
    logic                     r_clear,    w_clear_nxt;
    logic                     r_done,     w_done_nxt;
    logic [c_clr_w-1:0]       r_clr_cnt,  w_clr_cnt_nxt;

    logic [NUM_NEURONS-1:0]   w_rest;
    logic [NUM_NEURONS-1:0]   w_enc_in;
    logic [c_idx_w-1:0]       w_idx;
    logic                     w_any;
    logic                     w_capture;
    logic                     w_accept;

    assign w_capture = (r_state == IDLE) && spike_valid;
    assign w_accept  = r_valid && addr_ready;

    // Encoder looks ahead past the bit on the bus so the next address is ready
    // on the same edge the current one is accepted.
    assign w_rest   = r_pending & ~(c_one << r_cur_idx);
    assign w_enc_in = (r_state == IDLE) ? spike_in : w_rest;

    lowest_set_index #(
        .WIDTH (NUM_NEURONS),
        .IDX_W (c_idx_w)
    ) u_lsi (
        .i_vec     (w_enc_in),
        .o_idx     (w_idx),
        .o_any_set (w_any)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_cur_idx_nxt = r_cur_idx;
        w_addr_nxt    = r_addr;
        w_valid_nxt   = r_valid;
        w_clear_nxt   = r_clear;
        w_done_nxt    = 1'b0;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_pending_nxt = spike_in;
                    if (w_any) begin
                        w_state_nxt   = SEND;
                        w_cur_idx_nxt = w_idx;
                        w_addr_nxt    = c_base + ADDR_W'(w_idx);
                        w_valid_nxt   = 1'b1;
                    end else begin
                        w_state_nxt   = CLEAR;
                        w_clear_nxt   = 1'b1;
                        w_clr_cnt_nxt = c_clr_load;
                    end
                end
            end
            SEND: begin
                if (w_accept) begin
                    w_pending_nxt = w_rest;
                    if (w_any) begin
                        w_cur_idx_nxt = w_idx;
                        w_addr_nxt    = c_base + ADDR_W'(w_idx);
                    end else begin
                        w_state_nxt   = CLEAR;
                        w_valid_nxt   = 1'b0;
                        w_clear_nxt   = 1'b1;
                        w_clr_cnt_nxt = c_clr_load;
                    end
                end
            end
            CLEAR: begin
                if (r_clr_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_clear_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt - c_clr_w'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_clear_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_cur_idx <= '0;
            r_addr    <= '0;
            r_valid   <= 1'b0;
            r_clear   <= 1'b0;
            r_done    <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_cur_idx <= w_cur_idx_nxt;
            r_addr    <= w_addr_nxt;
            r_valid   <= w_valid_nxt;
            r_clear   <= w_clear_nxt;
            r_done    <= w_done_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    assign capture_ready  = (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign source_address = r_addr;
    assign addr_valid     = r_valid;
    assign clear          = r_clear;
    assign done           = r_done;

`ifdef SPIKE_COUNT_EN
    localparam int c_cnt_w = $clog2(NUM_NEURONS + 1);

    logic [c_cnt_w-1:0] r_spike_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_spike_count <= '0;
        end else if (w_capture) begin
            r_spike_count <= '0;
        end else if (w_accept) begin
            r_spike_count <= r_spike_count + c_cnt_w'(1);
        end
    end

    assign spike_count = r_spike_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spike_address_dispatcher.sv
//------------------------------------------------------------------------------
// Module  : tb_spike_address_dispatcher
// Brief   : Directed bench for spike_address_dispatcher (base 0 and base 4090).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spike_address_dispatcher;

    logic        CLK;
    logic        RST;
    logic [9:0]  spike_in;
    logic        spike_valid;
    logic        addr_ready;

    logic        capture_ready, addr_valid, clear, done, busy;
    logic [11:0] source_address;
    logic        w_capture_ready, w_addr_valid, w_clear, w_done, w_busy;
    logic [11:0] w_source_address;
`ifdef SPIKE_COUNT_EN
    logic [3:0]  spike_count;
    logic [3:0]  w_spike_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    spike_address_dispatcher #(
        .NUM_NEURONS (10), .ADDR_W (12), .BASE_ADDR (0), .CLEAR_CYCLES (4)
    ) dut (
        .CLK (CLK), .RST (RST), .spike_in (spike_in), .spike_valid (spike_valid),
        .capture_ready (capture_ready), .source_address (source_address),
        .addr_valid (addr_valid), .addr_ready (addr_ready), .clear (clear),
        .done (done), .busy (busy)
`ifdef SPIKE_COUNT_EN
        , .spike_count (spike_count)
`endif
    );

    spike_address_dispatcher #(
        .NUM_NEURONS (10), .ADDR_W (12), .BASE_ADDR (4090), .CLEAR_CYCLES (4)
    ) dut_w (
        .CLK (CLK), .RST (RST), .spike_in (spike_in), .spike_valid (spike_valid),
        .capture_ready (w_capture_ready), .source_address (w_source_address),
        .addr_valid (w_addr_valid), .addr_ready (addr_ready), .clear (w_clear),
        .done (w_done), .busy (w_busy)
`ifdef SPIKE_COUNT_EN
        , .spike_count (w_spike_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Four clear cycles (caller is already in the first), then the done pulse.
    task automatic check_close(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_clear"}, {31'd0, clear}, 32'd1);
            check({tag, "_novalid"}, {31'd0, addr_valid}, 32'd0);
            step();
        end
        check({tag, "_clear_fall"}, {31'd0, clear}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_ready"}, {31'd0, capture_ready}, 32'd1);
        step();
        check({tag, "_done_fall"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        RST         = 1'b1;
        spike_in    = '0;
        spike_valid = 1'b0;
        addr_ready  = 1'b0;
        #3;
        check("rst_capture_ready", {31'd0, capture_ready}, 32'd1);
        check("rst_addr_valid", {31'd0, addr_valid}, 32'd0);
        check("rst_clear", {31'd0, clear}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {20'd0, source_address}, 32'd0);
`ifdef SPIKE_COUNT_EN
        check("rst_count", {28'd0, spike_count}, 32'd0);
`endif
        step();
        step();
        RST = 1'b0;
        step();

        // Two spikes, receiver always ready.
        spike_in = 10'b0000000101; spike_valid = 1'b1; addr_ready = 1'b1;
        step();
        spike_valid = 1'b0;
        check("a_valid0", {31'd0, addr_valid}, 32'd1);
        check("a_addr0", {20'd0, source_address}, 32'd0);
        check("a_busy", {31'd0, busy}, 32'd1);
        check("a_not_ready", {31'd0, capture_ready}, 32'd0);
        step();
        check("a_valid1", {31'd0, addr_valid}, 32'd1);
        check("a_addr1", {20'd0, source_address}, 32'd2);
        step();
        check_close("a");

        // Back-pressure on the first address.
        spike_in = 10'b0000000101; spike_valid = 1'b1; addr_ready = 1'b0;
        step();
        spike_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("b_hold_valid", {31'd0, addr_valid}, 32'd1);
            check("b_hold_addr", {20'd0, source_address}, 32'd0);
            step();
        end
        addr_ready = 1'b1;
        check("b_addr0", {20'd0, source_address}, 32'd0);
        step();
        check("b_valid1", {31'd0, addr_valid}, 32'd1);
        check("b_addr1", {20'd0, source_address}, 32'd2);
        step();
        check_close("b");

        // Empty timestep still closes with clear.
        spike_in = 10'b0; spike_valid = 1'b1;
        step();
        spike_valid = 1'b0;
        check("c_busy", {31'd0, busy}, 32'd1);
        check_close("c");

        // All neurons fire; second instance wraps past the top of the address space.
        spike_in = 10'b1111111111; spike_valid = 1'b1; addr_ready = 1'b1;
        step();
        spike_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic [11:0] exp_w;
            exp_w = 12'd4090 + 12'(i);
            check("d_valid", {31'd0, addr_valid}, 32'd1);
            check("d_addr", {20'd0, source_address}, i);
            check("d_addr_wrap", {20'd0, w_source_address}, {20'd0, exp_w});
            step();
        end
        check("d_wrap_clear", {31'd0, w_clear}, 32'd1);
`ifdef SPIKE_COUNT_EN
        check("d_count", {28'd0, spike_count}, 32'd10);
        check("d_count_wrap", {28'd0, w_spike_count}, 32'd10);
`endif
        check_close("d");
`ifdef SPIKE_COUNT_EN
        check("d_count_hold", {28'd0, spike_count}, 32'd10);
`endif

        // New vector offered during SEND must be ignored.
        spike_in = 10'b0000000101; spike_valid = 1'b1; addr_ready = 1'b0;
        step();
        spike_in = 10'b0000000001;
        check("e_addr0", {20'd0, source_address}, 32'd0);
        step();
        step();
        spike_valid = 1'b0;
        addr_ready  = 1'b1;
        check("e_addr0_held", {20'd0, source_address}, 32'd0);
        step();
        check("e_addr1", {20'd0, source_address}, 32'd2);
        step();
        check_close("e");
        check("e_no_resend", {31'd0, addr_valid}, 32'd0);
        check("e_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of SEND.
        spike_in = 10'b0000000111; spike_valid = 1'b1; addr_ready = 1'b1;
        step();
        spike_valid = 1'b0;
        check("f_addr0", {20'd0, source_address}, 32'd0);
        step();
        check("f_addr1", {20'd0, source_address}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("f_async_valid", {31'd0, addr_valid}, 32'd0);
        check("f_async_clear", {31'd0, clear}, 32'd0);
        check("f_async_ready", {31'd0, capture_ready}, 32'd1);
        check("f_async_busy", {31'd0, busy}, 32'd0);
`ifdef SPIKE_COUNT_EN
        check("f_async_count", {28'd0, spike_count}, 32'd0);
`endif
        #1;
        RST = 1'b0;
        step();
        step();
        check("f_post_valid", {31'd0, addr_valid}, 32'd0);
        check("f_post_clear", {31'd0, clear}, 32'd0);
        check("f_post_ready", {31'd0, capture_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
